// File: rtl/button_debouncer.sv
// button_debouncer
// Conditions raw push-buttons for the operand/opcode latch stage. Each channel
// has a 2-flop synchroniser, a stability counter that accepts a level change
// only after DEBOUNCE_CYCLES consecutive differing samples, and a one-cycle
// pulse on every accepted press.
//
// Ports:
//   CLK            system clock, rising edge
//   RESET          asynchronous active-high reset, clears every flop
//   BUTTONS_RAW    raw asynchronous button pins, 1 = pressed
//   BUTTONS_LEVEL  debounced, registered button level
//   BUTTONS_PULSE  registered one-cycle pulse on each accepted press
//
// Build option:
//   DEBOUNCE_BYPASS_EN  when defined, removes the counters; LEVEL follows the
//                       synchronised input directly. Meant for fast simulation.
module button_debouncer #(
  parameter int unsigned N_BUTTONS       = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_WIDTH       = 20
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [N_BUTTONS-1:0] BUTTONS_RAW,
  output logic [N_BUTTONS-1:0] BUTTONS_LEVEL,
  output logic [N_BUTTONS-1:0] BUTTONS_PULSE
);

  logic [N_BUTTONS-1:0] sync1;
  logic [N_BUTTONS-1:0] sync2;

  // 2-flop synchroniser for the asynchronous pins
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= BUTTONS_RAW;
      sync2 <= sync1;
    end
  end

`ifdef DEBOUNCE_BYPASS_EN

  // Bypass: level tracks the synchronised input, pulse on its rising edge
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      BUTTONS_LEVEL <= '0;
      BUTTONS_PULSE <= '0;
    end else begin
      BUTTONS_LEVEL <= sync2;
      BUTTONS_PULSE <= sync2 & ~BUTTONS_LEVEL;
    end
  end

`else

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
    logic [CNT_WIDTH-1:0] cnt;
    logic                 level_q;
    logic                 pulse_q;

    // Stability counter: any sample equal to the current level restarts the
    // count, so bounce never reaches the terminal count. The counter is
    // cleared at the terminal count and never wraps.
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        cnt     <= '0;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        if (sync2[i] == level_q) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          level_q <= sync2[i];
          cnt     <= '0;
          // Only an accepted 0->1 change pulses; release accepts silently
          pulse_q <= sync2[i];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign BUTTONS_LEVEL[i] = level_q;
    assign BUTTONS_PULSE[i] = pulse_q;
  end

`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer with DEBOUNCE_CYCLES=4, CNT_WIDTH=3.
// Stimulus pushes expected pulses and levels (tagged with the edge number after
// which they must be visible); a monitor on the falling edge pops and compares.
module tb_button_debouncer;

  localparam int unsigned NB = 3;
  localparam int unsigned DC = 4;
  localparam int unsigned CW = 3;

  typedef struct {
    int            e;
    logic [NB-1:0] v;
  } exp_t;

  logic          CLK;
  logic          RESET;
  logic [NB-1:0] BUTTONS_RAW;
  logic [NB-1:0] BUTTONS_LEVEL;
  logic [NB-1:0] BUTTONS_PULSE;

  int   edge_cnt = 0;
  int   checks   = 0;
  int   failures = 0;
  exp_t pq[$];
  exp_t lq[$];
  exp_t mx;

  button_debouncer #(
    .N_BUTTONS      (NB),
    .DEBOUNCE_CYCLES(DC),
    .CNT_WIDTH      (CW)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .BUTTONS_RAW  (BUTTONS_RAW),
    .BUTTONS_LEVEL(BUTTONS_LEVEL),
    .BUTTONS_PULSE(BUTTONS_PULSE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, edge_cnt, act, req);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_cnt, act, req);
    end
  endtask

  // Monitor: pops expected pulses whenever PULSE is non-zero, levels by edge
  always @(negedge CLK) begin
    if (!RESET) begin
      while (pq.size() > 0 && pq[0].e < edge_cnt) begin
        mx = pq.pop_front();
        chk_int("pulse_missing", edge_cnt, mx.e);
      end
      if (BUTTONS_PULSE !== '0) begin
        if (pq.size() == 0) begin
          chk("pulse_unexpected", BUTTONS_PULSE, '0);
        end else begin
          mx = pq.pop_front();
          chk_int("pulse_edge", edge_cnt, mx.e);
          chk("pulse_vec", BUTTONS_PULSE, mx.v);
        end
      end
      while (lq.size() > 0 && lq[0].e <= edge_cnt) begin
        mx = lq.pop_front();
        chk("level", BUTTONS_LEVEL, mx.v);
      end
    end
  end

  task automatic push_p(input int e, input logic [NB-1:0] v);
    exp_t x;
    x.e = e;
    x.v = v;
    pq.push_back(x);
  endtask

  task automatic push_l(input int e, input logic [NB-1:0] v);
    exp_t x;
    x.e = e;
    x.v = v;
    lq.push_back(x);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Asynchronous reset pulse placed between two rising edges; outputs must
  // clear before any clock edge arrives
  task automatic mid_reset(input string name);
    #1 RESET = 1'b1;
    #1;
    chk({name, "_level"}, BUTTONS_LEVEL, '0);
    chk({name, "_pulse"}, BUTTONS_PULSE, '0);
    #1 RESET = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   e0;
    logic seq [10];
    seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    RESET       = 1'b1;
    BUTTONS_RAW = '0;
    wait_neg(2);
    chk("reset_level", BUTTONS_LEVEL, '0);
    chk("reset_pulse", BUTTONS_PULSE, '0);
    RESET = 1'b0;
    wait_neg(3);

    // Clean press on channel 0, held 20 cycles
    BUTTONS_RAW = 3'b001;
    e0 = edge_cnt + 1;
    push_l(e0 + 4, 3'b000);
    push_p(e0 + 5, 3'b001);
    push_l(e0 + 5, 3'b001);
    push_l(e0 + 6, 3'b001);
    push_l(e0 + 19, 3'b001);
    wait_neg(20);

    // Release: level drops after DC+1 edges, no pulse
    BUTTONS_RAW = 3'b000;
    e0 = edge_cnt + 1;
    push_l(e0 + 4, 3'b001);
    push_l(e0 + 5, 3'b000);
    wait_neg(10);

    // Bounce on channel 1, then stable high from edge 10
    e0 = edge_cnt + 1;
    push_l(e0 + 14, 3'b000);
    push_p(e0 + 15, 3'b010);
    push_l(e0 + 15, 3'b010);
    for (int i = 0; i < 10; i++) begin
      BUTTONS_RAW[1] = seq[i];
      wait_neg(1);
    end
    BUTTONS_RAW[1] = 1'b1;
    wait_neg(12);
    BUTTONS_RAW = 3'b000;
    wait_neg(10);

    // Simultaneous press on channels 0 and 2
    BUTTONS_RAW = 3'b101;
    e0 = edge_cnt + 1;
    push_l(e0 + 4, 3'b000);
    push_p(e0 + 5, 3'b101);
    push_l(e0 + 5, 3'b101);
    wait_neg(10);

    // Reset while held: outputs clear, then held buttons re-press
    mid_reset("reset_held");
    e0 = edge_cnt + 1;
    push_l(e0 + 4, 3'b000);
    push_p(e0 + 5, 3'b101);
    push_l(e0 + 5, 3'b101);
    wait_neg(10);
    BUTTONS_RAW = 3'b000;
    wait_neg(10);

    // Reset mid-count on channel 2 between edges 3 and 4
    BUTTONS_RAW = 3'b100;
    wait_neg(4);
    mid_reset("reset_midcount");
    e0 = edge_cnt + 1;
    push_l(e0 + 4, 3'b000);
    push_p(e0 + 5, 3'b100);
    push_l(e0 + 5, 3'b100);
    wait_neg(10);
    BUTTONS_RAW = 3'b000;
    wait_neg(10);

    // Reset one edge before a due pulse on channel 0: pulse is suppressed
    BUTTONS_RAW = 3'b001;
    wait_neg(5);
    mid_reset("reset_suppress");
    e0 = edge_cnt + 1;
    push_l(e0, 3'b000);
    push_l(e0 + 4, 3'b000);
    push_p(e0 + 5, 3'b001);
    push_l(e0 + 5, 3'b001);
    wait_neg(10);
    BUTTONS_RAW = 3'b000;
    wait_neg(10);

    chk_int("pulse_queue_drained", pq.size(), 0);
    chk_int("level_queue_drained", lq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions the raw board push-buttons before they reach the operand/opcode latch stage (DATOA/DATOB/OPCODE load enables).
- For each button it synchronises the raw input to CLK, filters contact bounce, and produces a one-cycle press pulse.
- Without this stage a single press loads a register for thousands of cycles and bounce causes spurious reloads.
- Its BUTTONS_PULSE output connects directly to the latch stage's BUTTONS input.

Parameters:
- N_BUTTONS, 3: number of independent button channels.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz). Must be >= 1.
- CNT_WIDTH, 20: width of each per-button stability counter. Must hold DEBOUNCE_CYCLES-1.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- BUTTONS_RAW  input  N_BUTTONS  raw asynchronous button pins; 1 = pressed.
- BUTTONS_LEVEL  output  N_BUTTONS  debounced, registered button level.
- BUTTONS_PULSE  output  N_BUTTONS  registered one-cycle pulse on each accepted press (0->1 of LEVEL).

Behaviour:
- Clocking and reset:
  - One clock, CLK.
  - RESET is asynchronous and active-high, applied to every flop: synchroniser stages, counters, LEVEL and PULSE all go to 0 immediately.
- Per channel (channels fully independent, no shared state):
  - 2-flop synchroniser: sync1 <= BUTTONS_RAW[i]; sync2 <= sync1.
  - Stability counter cnt[i], CNT_WIDTH bits.
- Debounce rule, each rising edge:
  - If sync2 == LEVEL[i]: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: LEVEL[i] <= sync2 and cnt <= 0.
  - Else: cnt <= cnt+1.
- Pulse rule: PULSE[i] <= 1 only on the edge where LEVEL[i] changes 0->1; PULSE[i] <= 0 on every other edge.
- Pulse shape:
  - Exactly one cycle wide per accepted press.
  - Accepted release (1->0) produces no pulse.
- Latency: edge 0 is the first edge that samples BUTTONS_RAW high, and raw stays high throughout. LEVEL and PULSE are updated at edge DEBOUNCE_CYCLES+1, so both are visible high after that edge.
- Bounce: any return of sync2 to LEVEL before the count completes clears cnt to 0; no level change and no pulse.
- Holding the button:
  - LEVEL stays 1 for as long as the button is held.
  - No further pulses until a release is accepted followed by a new press.
- DEBOUNCE_CYCLES = 1: LEVEL follows sync2 with 1 cycle of extra delay; the rule is unchanged.
- Simultaneous presses: several bits of PULSE may be high in the same cycle; this is legal and the downstream latch stage handles it.
- Reset mid-operation:
  - A count in progress is discarded.
  - A pulse due on the next edge is suppressed.
  - A button still held when RESET deasserts is treated as a new press: pulse DEBOUNCE_CYCLES+1 edges after the first post-reset edge that samples it high.
- Counter never wraps: it is cleared at the terminal count.

Optional Feature:
- Macro: DEBOUNCE_BYPASS_EN.
- When defined:
  - Counter logic is removed.
  - LEVEL[i] <= sync2 every edge.
  - PULSE[i] <= sync2 & ~LEVEL[i].
  - Latency from edge 0 to LEVEL/PULSE visible high: edge 2.
  - Intended for fast simulation and for top-level regressions.
- When undefined: full debounce as described above. This is the default and the synthesis build.

Test Plan (DEBOUNCE_CYCLES=4, CNT_WIDTH=3 unless noted):
- Clean press: RAW[0] 0->1 sampled at edge 0 and held 20 cycles -> LEVEL[0]=1 and PULSE[0]=1 after edge 5; PULSE[0]=0 after edge 6; exactly one pulse total.
- Bounce: RAW[1] toggles 1,0,1,0 on consecutive edges, then holds 1 from edge 10 -> no pulse before edge 15; a single PULSE[1] visible after edge 15.
- Release: after a clean press, RAW[0] 1->0 held -> LEVEL[0]=0 DEBOUNCE_CYCLES+1 edges later; PULSE stays 0 throughout.
- Simultaneous: RAW=3'b101 at edge 0, held -> PULSE=3'b101 in the same cycle after edge 5; PULSE[1]=0 always.
- Reset mid-count: RAW[2]=1 from edge 0, RESET pulsed between edges 3 and 4 -> all outputs 0 immediately; pulse after edge 4+5 (counting from the first post-reset sampling edge); no earlier pulse.
- DEBOUNCE_BYPASS_EN defined: RAW[0] 0->1 at edge 0 -> PULSE[0]=1 after edge 2 for one cycle; a single-cycle glitch on RAW[0] produces a pulse.
